// File: rtl/fp_regfile_scoreboard_if.sv
// -----------------------------------------------------------------------------
// fp_regfile_scoreboard_if
// Bundles the FP register file / scoreboard traffic into one connection.
//   Writeback (from FP units) : wb_en, wb_addr, wb_data
//   Issue (from decode)       : issue_en, issue_dst -> issue_ack
//   Read ports                : rs_addr/rt_addr -> rs_data/rt_data,
//                               rs_busy/rt_busy, stall
//   Status                    : pending_count (number of outstanding writes)
// master : the side driving writebacks, issues and read addresses.
// slave  : the register file / scoreboard itself.
// -----------------------------------------------------------------------------
interface fp_regfile_scoreboard_if #(
    parameter int WIDTH = 32
) ();
    logic             wb_en;
    logic [4:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             issue_en;
    logic [4:0]       issue_dst;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             rs_busy;
    logic             rt_busy;
    logic             stall;
    logic             issue_ack;
    logic [5:0]       pending_count;

    modport master (
        output wb_en, wb_addr, wb_data, issue_en, issue_dst, rs_addr, rt_addr,
        input  rs_data, rt_data, rs_busy, rt_busy, stall, issue_ack, pending_count
    );

    modport slave (
        input  wb_en, wb_addr, wb_data, issue_en, issue_dst, rs_addr, rt_addr,
        output rs_data, rt_data, rs_busy, rt_busy, stall, issue_ack, pending_count
    );
endinterface

// File: rtl/fp_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// fp_regfile_scoreboard
// 32-entry FP register file with a per-register pending-write scoreboard.
// Decode issues a destination (sets its pending bit); an FP unit writeback
// stores the data and clears the pending bit. Reads are combinational and
// return data plus busy flags and a combined stall.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears data, pending bits and count
//   bus   - fp_regfile_scoreboard_if.slave (writeback, issue, read ports,
//           pending_count)
// Parameters:
//   WIDTH    - register width
//   ZERO_REG - 1: entry 0 reads zero, is never pending, ignores writes
//   BYPASS   - 1: same-cycle writeback data/clear is visible to readers
// -----------------------------------------------------------------------------
module fp_regfile_scoreboard #(
    parameter int WIDTH    = 32,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    fp_regfile_scoreboard_if.slave bus
);

    logic [31:0][WIDTH-1:0] regs_q;
    logic [31:0][WIDTH-1:0] regs_d;
    logic [31:0]            pending_q;
    logic [31:0]            pending_d;
    logic [5:0]             pending_count_q;
    logic [5:0]             pending_count_d;
    logic                   wr_en_s;
    logic                   rs_busy_s;
    logic                   rt_busy_s;
    logic                   dst_busy_s;
    logic                   stall_s;
    logic                   ack_s;
    logic                   set_en_s;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic is_zero(input logic [4:0] a);
        return ZERO_REG && (a == 5'd0);
    endfunction

    // A writeback landing this cycle hides the pending bit it is about to clear.
    function automatic logic eff_busy(input logic [31:0] pend, input logic wb_en,
                                      input logic [4:0] wb_addr, input logic [4:0] a);
        return !is_zero(a) && pend[a] && !(BYPASS && wb_en && (wb_addr == a));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [31:0][WIDTH-1:0] regs,
                                                   input logic wb_en,
                                                   input logic [4:0] wb_addr,
                                                   input logic [WIDTH-1:0] wb_data,
                                                   input logic [4:0] a);
        logic [WIDTH-1:0] v;
        if (is_zero(a)) begin
            v = '0;
        end else if (BYPASS && wb_en && (wb_addr == a)) begin
            v = wb_data;
        end else begin
            v = regs[a];
        end
        return v;
    endfunction

    // Read ports, busy flags, stall and issue acknowledge.
    always_comb begin
        rs_busy_s  = eff_busy(pending_q, bus.wb_en, bus.wb_addr, bus.rs_addr);
        rt_busy_s  = eff_busy(pending_q, bus.wb_en, bus.wb_addr, bus.rt_addr);
        dst_busy_s = eff_busy(pending_q, bus.wb_en, bus.wb_addr, bus.issue_dst);
        // Destination hazard only matters while decode is actually issuing.
        stall_s    = rs_busy_s | rt_busy_s | (bus.issue_en & dst_busy_s);
        ack_s      = bus.issue_en & ~stall_s;

        bus.rs_data       = read_port(regs_q, bus.wb_en, bus.wb_addr, bus.wb_data, bus.rs_addr);
        bus.rt_data       = read_port(regs_q, bus.wb_en, bus.wb_addr, bus.wb_data, bus.rt_addr);
        bus.rs_busy       = rs_busy_s;
        bus.rt_busy       = rt_busy_s;
        bus.stall         = stall_s;
        bus.issue_ack     = ack_s;
        bus.pending_count = pending_count_q;
    end

    // Next register contents, pending vector and count.
    always_comb begin
        wr_en_s  = bus.wb_en & ~is_zero(bus.wb_addr);
        set_en_s = ack_s & ~is_zero(bus.issue_dst);

        regs_d    = regs_q;
        pending_d = pending_q;

        regs_d[bus.wb_addr]    = wr_en_s ? bus.wb_data : regs_q[bus.wb_addr];
        pending_d[bus.wb_addr] = pending_d[bus.wb_addr] & ~wr_en_s;
        // Applied after the clear so a same-address issue leaves the bit set.
        pending_d[bus.issue_dst] = pending_d[bus.issue_dst] | set_en_s;

        pending_count_d = popcount32(pending_d);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q          <= '0;
            pending_q       <= 32'd0;
            pending_count_q <= 6'd0;
        end else begin
            regs_q          <= regs_d;
            pending_q       <= pending_d;
            pending_count_q <= pending_count_d;
        end
    end

endmodule
